// File: rtl/modifier_keys_pkg.sv
// Shared scancode constants, modifier table and prefix FSM encodings for the
// PS/2 Set-2 modifier tracker (modifier_keys, ps2_prefix_fsm).
package modifier_keys_pkg;

    localparam int MAX_MODS = 8;

    // Prefix bytes
    localparam logic [7:0] SC_E0   = 8'hE0;
    localparam logic [7:0] SC_F0   = 8'hF0;
    localparam logic [7:0] SC_E1   = 8'hE1;
    localparam logic [7:0] SC_CAPS = 8'h58;

    // Modifier codes, index order matches the o_mods bit order
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_RCTRL  = 8'h14;
    localparam logic [7:0] SC_LALT   = 8'h11;
    localparam logic [7:0] SC_RALT   = 8'h11;
    localparam logic [7:0] SC_LGUI   = 8'h1F;
    localparam logic [7:0] SC_RGUI   = 8'h27;

    localparam logic [8*MAX_MODS-1:0] MOD_CODES = {
        SC_RGUI, SC_LGUI, SC_RALT, SC_LALT,
        SC_RCTRL, SC_LCTRL, SC_RSHIFT, SC_LSHIFT
    };
    // 1 = entry only matches when preceded by E0
    localparam logic [MAX_MODS-1:0] MOD_EXT_FLAGS = 8'b1110_1000;

    localparam int IDX_LSHIFT = 0;
    localparam int IDX_RSHIFT = 1;
    localparam int IDX_LCTRL  = 2;
    localparam int IDX_RCTRL  = 3;
    localparam int IDX_LALT   = 4;
    localparam int IDX_RALT   = 5;

    // Bytes that follow E1 in the Pause make sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_BRK    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_PAUSE  = 3'd4
    } prefix_state_t;

endpackage

// File: rtl/flopr_en.sv
// Register with asynchronous active-low reset, synchronous clear and enable.
module flopr_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_sclr,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= '0;
        end else if (i_sclr) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/ps2_prefix_fsm.sv
// Decodes E0 / F0 / E1 prefixes of a PS/2 Set-2 byte stream and emits one
// single-cycle code strobe per complete make or break code.
import modifier_keys_pkg::*;

module ps2_prefix_fsm (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_sclr,
    input  logic          i_byte_en,
    input  logic [7:0]    i_byte,
    output logic          o_code_valid,
    output logic [7:0]    o_code_byte,
    output logic          o_is_ext,
    output logic          o_is_break,
    output prefix_state_t o_state
);

    prefix_state_t state_q, state_d;
    logic [2:0]    skip_q, skip_d;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else if (i_sclr) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // Code strobes are combinational so the mask updates on the same edge
    // that accepts the final byte.
    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        o_code_valid = 1'b0;
        o_is_ext     = 1'b0;
        o_is_break   = 1'b0;
        if (i_byte_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_byte == SC_E0) begin
                        state_d = ST_EXT;
                    end else if (i_byte == SC_F0) begin
                        state_d = ST_BRK;
                    end else if (i_byte == SC_E1) begin
                        state_d = ST_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else begin
                        o_code_valid = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (i_byte == SC_F0) begin
                        state_d = ST_EXTBRK;
                    end else if (i_byte != SC_E0) begin
                        o_code_valid = 1'b1;
                        o_is_ext     = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXTBRK: begin
                    // A stray prefix here aborts the code without touching the mask
                    state_d = ST_IDLE;
                    if (i_byte != SC_F0 && i_byte != SC_E0) begin
                        o_code_valid = 1'b1;
                        o_is_break   = 1'b1;
                        o_is_ext     = (state_q == ST_EXTBRK);
                    end
                end
                ST_PAUSE: begin
                    if (skip_q <= 3'd1) begin
                        skip_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = '0;
                end
            endcase
        end
    end

    assign o_code_byte = i_byte;
    assign o_state     = state_q;

endmodule

// File: rtl/modifier_keys.sv
// PS/2 Set-2 modifier tracker: held-modifier mask, merged shift/ctrl/alt flags.
// Define CAPS_LOCK_EN to add the o_caps toggle output.
import modifier_keys_pkg::*;

module modifier_keys #(
    parameter int NUM_MODS = 8
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_sclr,
    input  logic                i_byte_en,
    input  logic [7:0]          i_byte,
    output logic [NUM_MODS-1:0] o_mods,
    output logic                o_shift,
    output logic                o_ctrl,
    output logic                o_alt,
    output logic                o_mod_chg,
`ifdef CAPS_LOCK_EN
    output logic                o_caps,
`endif
    output logic [2:0]          o_fsm_state
);

    logic          code_valid;
    logic [7:0]    code_byte;
    logic          is_ext;
    logic          is_break;
    prefix_state_t fsm_state;

    ps2_prefix_fsm u_prefix (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_sclr       (i_sclr),
        .i_byte_en    (i_byte_en),
        .i_byte       (i_byte),
        .o_code_valid (code_valid),
        .o_code_byte  (code_byte),
        .o_is_ext     (is_ext),
        .o_is_break   (is_break),
        .o_state      (fsm_state)
    );

    assign o_fsm_state = fsm_state;

    logic [NUM_MODS-1:0] hit;
    logic [NUM_MODS-1:0] mods_q;
    logic [NUM_MODS-1:0] mods_d;
    logic                mod_chg_q;

    for (genvar g = 0; g < NUM_MODS; g++) begin : g_match
        assign hit[g] = code_valid
                     && (code_byte == MOD_CODES[g*8 +: 8])
                     && (is_ext == MOD_EXT_FLAGS[g]);
    end

    assign mods_d = (mods_q & ~hit) | (hit & {NUM_MODS{~is_break}});

    flopr_en #(.W(NUM_MODS)) u_mask (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_sclr  (i_sclr),
        .i_en    (code_valid),
        .i_d     (mods_d),
        .o_q     (mods_q)
    );

    // Repeated makes of a held key leave mods_d equal to mods_q: no pulse
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mod_chg_q <= 1'b0;
        end else if (i_sclr) begin
            mod_chg_q <= 1'b0;
        end else begin
            mod_chg_q <= (mods_d != mods_q);
        end
    end

    assign o_mods    = mods_q;
    assign o_mod_chg = mod_chg_q;

    // Function bits 0..5; entries beyond NUM_MODS read as released
    logic [5:0] fn_bits;
    for (genvar g = 0; g < 6; g++) begin : g_fn
        if (g < NUM_MODS) begin : g_live
            assign fn_bits[g] = mods_q[g];
        end else begin : g_absent
            assign fn_bits[g] = 1'b0;
        end
    end

    assign o_shift = fn_bits[IDX_LSHIFT] | fn_bits[IDX_RSHIFT];
    assign o_ctrl  = fn_bits[IDX_LCTRL]  | fn_bits[IDX_RCTRL];
    assign o_alt   = fn_bits[IDX_LALT]   | fn_bits[IDX_RALT];

`ifdef CAPS_LOCK_EN
    logic caps_q;
    logic caps_armed_q;
    logic caps_make;
    logic caps_brk;

    assign caps_make = code_valid && !is_ext && !is_break && (code_byte == SC_CAPS);
    assign caps_brk  = code_valid && !is_ext &&  is_break && (code_byte == SC_CAPS);

    // Armed by the break so typematic repeats of the make do not toggle
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            caps_q       <= 1'b0;
            caps_armed_q <= 1'b1;
        end else if (i_sclr) begin
            caps_q       <= 1'b0;
            caps_armed_q <= 1'b1;
        end else if (caps_make && caps_armed_q) begin
            caps_q       <= ~caps_q;
            caps_armed_q <= 1'b0;
        end else if (caps_brk) begin
            caps_armed_q <= 1'b1;
        end
    end

    assign o_caps = caps_q;
`endif

endmodule

// File: tb/tb_modifier_keys.sv
// Directed vector bench for modifier_keys (8-entry instance plus a 2-entry one).
module tb_modifier_keys;

    logic       clk;
    logic       i_rst_n;
    logic       i_sclr;
    logic       i_byte_en;
    logic [7:0] i_byte;

    logic [7:0] o_mods;
    logic       o_shift, o_ctrl, o_alt, o_mod_chg;
    logic [2:0] o_fsm_state;
    logic [1:0] o_mods2;
    logic       o_shift2, o_ctrl2, o_alt2, o_mod_chg2;
    logic [2:0] o_fsm_state2;
`ifdef CAPS_LOCK_EN
    logic       o_caps, o_caps2;
`endif

    int checks = 0;
    int errors = 0;

    modifier_keys #(.NUM_MODS(8)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_sclr      (i_sclr),
        .i_byte_en   (i_byte_en),
        .i_byte      (i_byte),
        .o_mods      (o_mods),
        .o_shift     (o_shift),
        .o_ctrl      (o_ctrl),
        .o_alt       (o_alt),
        .o_mod_chg   (o_mod_chg),
`ifdef CAPS_LOCK_EN
        .o_caps      (o_caps),
`endif
        .o_fsm_state (o_fsm_state)
    );

    modifier_keys #(.NUM_MODS(2)) dut2 (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_sclr      (i_sclr),
        .i_byte_en   (i_byte_en),
        .i_byte      (i_byte),
        .o_mods      (o_mods2),
        .o_shift     (o_shift2),
        .o_ctrl      (o_ctrl2),
        .o_alt       (o_alt2),
        .o_mod_chg   (o_mod_chg2),
`ifdef CAPS_LOCK_EN
        .o_caps      (o_caps2),
`endif
        .o_fsm_state (o_fsm_state2)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       sclr;
        logic       en;
        logic [7:0] b;
        logic [7:0] mods;
        logic       chg;
        logic [2:0] st;
        logic       caps;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sclr, input logic en, input logic [7:0] b,
                                input logic [7:0] mods, input logic chg,
                                input logic [2:0] st, input logic caps);
        vec_t v;
        v.sclr = sclr; v.en = en; v.b = b;
        v.mods = mods; v.chg = chg; v.st = st; v.caps = caps;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input vec_t v);
        chk({tag, " mods"},  o_mods, v.mods);
        chk({tag, " chg"},   {7'b0, o_mod_chg}, {7'b0, v.chg});
        chk({tag, " state"}, {5'b0, o_fsm_state}, {5'b0, v.st});
        chk({tag, " shift"}, {7'b0, o_shift}, {7'b0, v.mods[0] | v.mods[1]});
        chk({tag, " ctrl"},  {7'b0, o_ctrl},  {7'b0, v.mods[2] | v.mods[3]});
        chk({tag, " alt"},   {7'b0, o_alt},   {7'b0, v.mods[4] | v.mods[5]});
`ifdef CAPS_LOCK_EN
        chk({tag, " caps"},  {7'b0, o_caps},  {7'b0, v.caps});
`endif
    endtask

    // driver: present one cycle of inputs, sample 1 ns after the edge
    task automatic apply(input string tag, input vec_t v);
        i_sclr    = v.sclr;
        i_byte_en = v.en;
        i_byte    = v.b;
        @(posedge clk);
        #1;
        i_sclr    = 1'b0;
        i_byte_en = 1'b0;
        check_main(tag, v);
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_sclr    = 1'b0;
        i_byte_en = 1'b0;
        i_byte    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_main("reset", mk(0, 0, 8'h00, 8'h00, 0, 3'd0, 0));
        chk("reset mods2", {6'b0, o_mods2}, 8'h00);
        i_rst_n = 1'b1;

        // {sclr, en, byte, exp mods, exp chg, exp state, exp caps}
        // make / break LSHIFT
        vecs.push_back(mk(0, 1, 8'h12, 8'h01, 1, 3'd0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h01, 0, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h01, 0, 3'd2, 0));
        vecs.push_back(mk(0, 1, 8'h12, 8'h00, 1, 3'd0, 0));
        // RCTRL, LCTRL, then release RCTRL
        vecs.push_back(mk(0, 1, 8'hE0, 8'h00, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'h14, 8'h08, 1, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h14, 8'h0C, 1, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'h0C, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h0C, 0, 3'd3, 0));
        vecs.push_back(mk(0, 1, 8'h14, 8'h04, 1, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h04, 0, 3'd2, 0));
        vecs.push_back(mk(0, 1, 8'h14, 8'h00, 1, 3'd0, 0));
        // Pause sequence
        vecs.push_back(mk(0, 1, 8'hE1, 8'h00, 0, 3'd4, 0));
        vecs.push_back(mk(0, 1, 8'h14, 8'h00, 0, 3'd4, 0));
        vecs.push_back(mk(0, 1, 8'h77, 8'h00, 0, 3'd4, 0));
        vecs.push_back(mk(0, 1, 8'hE1, 8'h00, 0, 3'd4, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 3'd4, 0));
        vecs.push_back(mk(0, 1, 8'h14, 8'h00, 0, 3'd4, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 3'd4, 0));
        vecs.push_back(mk(0, 1, 8'h77, 8'h00, 0, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h14, 8'h04, 1, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h04, 0, 3'd2, 0));
        vecs.push_back(mk(0, 1, 8'h14, 8'h00, 1, 3'd0, 0));
        // fake shifts and print screen
        vecs.push_back(mk(0, 1, 8'hE0, 8'h00, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'h12, 8'h00, 0, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'h00, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'h7C, 8'h00, 0, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'h00, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 3'd3, 0));
        vecs.push_back(mk(0, 1, 8'h59, 8'h00, 0, 3'd0, 0));
        // typematic repeat
        vecs.push_back(mk(0, 1, 8'h12, 8'h01, 1, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h12, 8'h01, 0, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h12, 8'h01, 0, 3'd0, 0));
        // protocol errors: F0 F0, E0 E0, E0 F0 E0
        vecs.push_back(mk(0, 1, 8'hF0, 8'h01, 0, 3'd2, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h01, 0, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h59, 8'h03, 1, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'h03, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'h03, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'h11, 8'h23, 1, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'h23, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h23, 0, 3'd3, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'h23, 0, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h11, 8'h33, 1, 3'd0, 0));
        // GUI keys
        vecs.push_back(mk(0, 1, 8'hE0, 8'h33, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'h27, 8'hB3, 1, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'hB3, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'h1F, 8'hF3, 1, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'hF3, 0, 3'd1, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 8'hF3, 0, 3'd3, 0));
        vecs.push_back(mk(0, 1, 8'h27, 8'h73, 1, 3'd0, 0));
        // synchronous clear: priority over a byte, discards a prefix
        vecs.push_back(mk(1, 1, 8'h14, 8'h00, 0, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 8'h00, 0, 3'd1, 0));
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h14, 8'h04, 1, 3'd0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0, 3'd0, 0));
        // Caps Lock toggling (ignored when the feature is absent)
        vecs.push_back(mk(0, 1, 8'h58, 8'h00, 0, 3'd0, 1));
        vecs.push_back(mk(0, 1, 8'h58, 8'h00, 0, 3'd0, 1));
        vecs.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 3'd2, 1));
        vecs.push_back(mk(0, 1, 8'h58, 8'h00, 0, 3'd0, 1));
        vecs.push_back(mk(0, 1, 8'h58, 8'h00, 0, 3'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // async reset in the middle of E0 F0, then 11 decodes as LALT make
        apply("ar_make", mk(0, 1, 8'h12, 8'h01, 1, 3'd0, 0));
        apply("ar_e0",   mk(0, 1, 8'hE0, 8'h01, 0, 3'd1, 0));
        apply("ar_f0",   mk(0, 1, 8'hF0, 8'h01, 0, 3'd3, 0));
        i_rst_n = 1'b0;
        #1;
        check_main("ar_async", mk(0, 0, 8'h00, 8'h00, 0, 3'd0, 0));
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        apply("ar_lalt", mk(0, 1, 8'h11, 8'h10, 1, 3'd0, 0));

        // two-entry instance: only LSHIFT and RSHIFT exist
        apply("n2_clr", mk(1, 0, 8'h00, 8'h00, 0, 3'd0, 0));
        apply("n2_14",  mk(0, 1, 8'h14, 8'h04, 1, 3'd0, 0));
        chk("n2_14 mods2", {6'b0, o_mods2}, 8'h00);
        chk("n2_14 ctrl2", {7'b0, o_ctrl2}, 8'h00);
        chk("n2_14 chg2",  {7'b0, o_mod_chg2}, 8'h00);
        apply("n2_12",  mk(0, 1, 8'h12, 8'h05, 1, 3'd0, 0));
        chk("n2_12 mods2",  {6'b0, o_mods2}, 8'h01);
        chk("n2_12 shift2", {7'b0, o_shift2}, 8'h01);
        chk("n2_12 chg2",   {7'b0, o_mod_chg2}, 8'h01);
        apply("n2_59",  mk(0, 1, 8'h59, 8'h07, 1, 3'd0, 0));
        chk("n2_59 mods2", {6'b0, o_mods2}, 8'h03);
        chk("n2_59 alt2",  {7'b0, o_alt2}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
